// File: rtl/request_arbiter16_pkg.sv
// Shared constants, types and helpers for the 16-requester arbiter.
// Imported by the priority encoder and the top level.
package request_arbiter16_pkg;

   localparam int NUM_REQ = 16;
   localparam int ID_W    = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Rotate left by 'amt' positions. The shifted-out bits wrap around.
   function automatic logic [NUM_REQ-1:0] rotl16(input logic [NUM_REQ-1:0] vec,
                                                 input logic [ID_W-1:0]    amt);
      logic [2*NUM_REQ-1:0] doubled;
      doubled = {vec, vec} << amt;
      return doubled[2*NUM_REQ-1:NUM_REQ];
   endfunction

   // Build a one-hot vector with only bit 'idx' set.
   function automatic logic [NUM_REQ-1:0] onehot16(input logic [ID_W-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage : request_arbiter16_pkg

// File: rtl/request_arbiter16_prio_enc16.sv
// Combinational 16-input priority encoder: the highest set index wins.
// valid_o is low when no input bit is set, and idx_o is then 0.
module prio_enc16
   import request_arbiter16_pkg::*;
(
   input  logic [NUM_REQ-1:0] in_i,
   output logic [ID_W-1:0]    idx_o,
   output logic               valid_o
);

   // Scan upward so that a later, higher set bit overwrites any lower one.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (in_i[i]) begin
            idx_o = ID_W'(i);
         end
      end
   end

   assign valid_o = |in_i;

endmodule : prio_enc16

// File: rtl/request_arbiter16.sv
// Registered 16-requester arbiter with fixed-priority and round-robin modes.
// Holds each grant until the owner releases it or the hold limit expires.
module request_arbiter16
   import request_arbiter16_pkg::*;
#(
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               mode,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_valid,
   output logic               timeout
);

   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [ID_W-1:0]     grantId_q;
   logic                grantValid_q;
   logic                timeout_q;
   logic [HOLD_W-1:0]   holdCnt_q;
   logic [ID_W-1:0]     lastId_q;

   logic [NUM_REQ-1:0]  fixedIn;
   logic [ID_W-1:0]     fixedIdx;
   logic                fixedValid;

   logic [ID_W-1:0]     rotAmt;
   logic [NUM_REQ-1:0]  rotReq;
   logic [ID_W-1:0]     rotIdx;
   logic                rotValid;

   logic [ID_W-1:0]     winnerId_d;
   logic                ownerHolding;
   logic                holdExpired;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   assign fixedIn = req;

   prio_enc16 u_fixedEnc (
      .in_i    (fixedIn),
      .idx_o   (fixedIdx),
      .valid_o (fixedValid)
   );

   // Rotating by -lastId puts requester lastId-1 at bit 15, so the encoder's
   // highest-wins rule yields the round-robin search order; adding lastId back
   // (mod 16) undoes the rotation.
   assign rotAmt = ID_W'(0) - lastId_q;
   assign rotReq = rotl16(req, rotAmt);

   prio_enc16 u_rrEnc (
      .in_i    (rotReq),
      .idx_o   (rotIdx),
      .valid_o (rotValid)
   );

   always_comb begin
      winnerId_d = fixedIdx;
      if (mode && rotValid) begin
         winnerId_d = rotIdx + lastId_q;
      end
   end

   assign ownerHolding = req[grantId_q];
   assign holdExpired  = (holdCnt_q >= HOLD_LAST);

   // Single FSM process. Every output is a register, so nothing on req
   // reaches the ports without passing through a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         grantId_q    <= '0;
         grantValid_q <= 1'b0;
         timeout_q    <= 1'b0;
         holdCnt_q    <= '0;
         lastId_q     <= '0;
      end else if (ena) begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fixedValid) begin
                  grant_q      <= onehot16(winnerId_d);
                  grantId_q    <= winnerId_d;
                  grantValid_q <= 1'b1;
                  holdCnt_q    <= '0;
                  lastId_q     <= winnerId_d;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               if (!ownerHolding) begin
                  grant_q      <= '0;
                  grantId_q    <= '0;
                  grantValid_q <= 1'b0;
                  state_q      <= IDLE;
               end else if (!holdExpired) begin
                  holdCnt_q <= holdCnt_q + HOLD_W'(1);
               end else begin
                  // Forced revocation. lastId still names this owner, which
                  // makes it the last candidate in the next round-robin search.
                  grant_q      <= '0;
                  grantId_q    <= '0;
                  grantValid_q <= 1'b0;
                  timeout_q    <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_id    = grantId_q;
   assign grant_valid = grantValid_q;
   assign timeout     = timeout_q;

endmodule : request_arbiter16
